// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default penalties for the ID-stage hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_e;

  localparam int unsigned HZ_CNT_W         = 3;
  localparam int unsigned DEF_LOAD_BR_PEN  = 2;
  localparam int unsigned DEF_LOAD_USE_PEN = 1;
  localparam int unsigned DEF_ALU_BR_PEN   = 1;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module hz_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load/ALU-to-ID dependency stalls, branch
// mispredict flush, external flush override and saturating perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RS       = 2,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned LOAD_BR_PEN  = DEF_LOAD_BR_PEN,
  parameter int unsigned LOAD_USE_PEN = DEF_LOAD_USE_PEN,
  parameter int unsigned ALU_BR_PEN   = DEF_ALU_BR_PEN,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [NUM_RS*REG_W-1:0] id_rs,
  input  logic [NUM_RS-1:0]       id_rs_used,
  input  logic                    id_is_branch,
  input  logic                    id_is_jalr,
  input  logic                    id_branch_taken,
  input  logic                    id_predict_taken,
  input  logic                    ex_reg_write,
  input  logic                    ex_mem_read,
  input  logic [REG_W-1:0]        ex_rd,
  input  logic                    ext_flush,
  input  logic                    perf_clr,
  output logic                    stall,
  output logic                    flush,
  output logic                    mispredict,
  output logic [2:0]              stall_remaining,
  output logic [CNT_W-1:0]        perf_stall_cycles,
  output logic [CNT_W-1:0]        perf_flushes
);

  hz_state_e             state_d, state_q;
  logic [HZ_CNT_W-1:0]   cnt_d, cnt_q;
  logic [NUM_RS-1:0]     match_c;
  logic                  dep_c, br_c;
  logic [HZ_CNT_W-1:0]   pen_c;
  logic                  stall_c, mispredict_c;
  logic [HZ_CNT_W-1:0]   rem_c;

  always_comb begin
    for (int k = 0; k < NUM_RS; k++) begin
      match_c[k] = id_valid && id_rs_used[k] && (ex_rd != '0) &&
                   (id_rs[k*REG_W +: REG_W] == ex_rd);
    end
  end

  assign dep_c = |match_c;
  assign br_c  = id_is_branch | id_is_jalr;

  // Penalty priority: load->branch, load->use, ALU->branch.
  always_comb begin
    pen_c = '0;
    if (ex_mem_read && dep_c && br_c)       pen_c = HZ_CNT_W'(LOAD_BR_PEN);
    else if (ex_mem_read && dep_c)          pen_c = HZ_CNT_W'(LOAD_USE_PEN);
    else if (ex_reg_write && dep_c && br_c) pen_c = HZ_CNT_W'(ALU_BR_PEN);
  end

  // Stall sequencing; ext_flush aborts any pending stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    rem_c   = '0;
    if (ext_flush) begin
      state_d = HZ_IDLE;
      cnt_d   = '0;
    end else if (state_q == HZ_HOLD) begin
      stall_c = 1'b1;
      rem_c   = cnt_q - HZ_CNT_W'(1);
      cnt_d   = cnt_q - HZ_CNT_W'(1);
      if (cnt_q == HZ_CNT_W'(1)) begin
        state_d = HZ_IDLE;
        cnt_d   = '0;
      end
    end else if (pen_c != '0) begin
      stall_c = 1'b1;
      rem_c   = pen_c - HZ_CNT_W'(1);
      if (pen_c > HZ_CNT_W'(1)) begin
        state_d = HZ_HOLD;
        cnt_d   = pen_c - HZ_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mispredict_c = id_valid && id_is_branch && !stall_c && !ext_flush &&
                        (id_branch_taken != id_predict_taken);

  // Reset forces the handshake outputs low regardless of inputs.
  assign stall           = stall_c && !rst;
  assign mispredict      = mispredict_c && !rst;
  assign flush           = (mispredict_c || ext_flush) && !rst;
  assign stall_remaining = rst ? 3'd0 : 3'(rem_c);

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .clr   (perf_clr),
    .count (perf_stall_cycles)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .clr   (perf_clr),
    .count (perf_flushes)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a
// countdown reference model, on default, ALU_BR_PEN=0 and CNT_W=4 builds.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_is_branch, id_is_jalr, id_branch_taken, id_predict_taken;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic        ex_reg_write, ex_mem_read, ext_flush, perf_clr;
  logic [4:0]  ex_rd;

  logic        d_stall, d_flush, d_mis;
  logic [2:0]  d_rem;
  logic [15:0] d_psc, d_pfl;
  logic        a_stall, a_flush, a_mis;
  logic [2:0]  a_rem;
  logic [15:0] a_psc, a_pfl;
  logic        c_stall, c_flush, c_mis;
  logic [2:0]  c_rem;
  logic [3:0]  c_psc, c_pfl;

  int nerr = 0;
  int nchk = 0;
  int pend_d = 0, pend_a = 0;
  int ps16 = 0, pf16 = 0, ps4 = 0, pf4 = 0;
  logic       s_stall, s_mis, s_flush, s_stall_a;
  logic [2:0] s_rem;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_is_branch(id_is_branch), .id_is_jalr(id_is_jalr), .id_branch_taken(id_branch_taken),
    .id_predict_taken(id_predict_taken), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ext_flush(ext_flush), .perf_clr(perf_clr), .stall(d_stall), .flush(d_flush),
    .mispredict(d_mis), .stall_remaining(d_rem), .perf_stall_cycles(d_psc), .perf_flushes(d_pfl)
  );

  hazard_ctrl #(.ALU_BR_PEN(0)) dut_a0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_is_branch(id_is_branch), .id_is_jalr(id_is_jalr), .id_branch_taken(id_branch_taken),
    .id_predict_taken(id_predict_taken), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ext_flush(ext_flush), .perf_clr(perf_clr), .stall(a_stall), .flush(a_flush),
    .mispredict(a_mis), .stall_remaining(a_rem), .perf_stall_cycles(a_psc), .perf_flushes(a_pfl)
  );

  hazard_ctrl #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_is_branch(id_is_branch), .id_is_jalr(id_is_jalr), .id_branch_taken(id_branch_taken),
    .id_predict_taken(id_predict_taken), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ext_flush(ext_flush), .perf_clr(perf_clr), .stall(c_stall), .flush(c_flush),
    .mispredict(c_mis), .stall_remaining(c_rem), .perf_stall_cycles(c_psc), .perf_flushes(c_pfl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stall cycles demanded by the current ID/EX pair for a given penalty set.
  function automatic int penalty(input int lbp, input int lup, input int abp);
    bit dep = 1'b0;
    bit br  = id_is_branch || id_is_jalr;
    for (int k = 0; k < 2; k++)
      if (id_valid && id_rs_used[k] && ex_rd != 5'd0 && id_rs[k*5 +: 5] == ex_rd) dep = 1'b1;
    if (ex_mem_read && dep && br) return lbp;
    if (ex_mem_read && dep)       return lup;
    if (ex_reg_write && dep && br) return abp;
    return 0;
  endfunction

  // pend = stall cycles still owed from an earlier detection.
  task automatic model_cycle(input int pend, input int pen, output bit stl, output int rem,
                             output int nxt);
    if (rst || ext_flush) begin
      stl = 1'b0; rem = 0; nxt = 0;
    end else if (pend > 0) begin
      stl = 1'b1; rem = pend - 1; nxt = pend - 1;
    end else begin
      stl = (pen > 0); rem = (pen > 0) ? pen - 1 : 0; nxt = rem;
    end
  endtask

  task automatic step();
    bit sd, sa, md, ma, fd, fa;
    int rd, ra, nd, na;
    @(negedge clk);
    model_cycle(pend_d, penalty(2, 1, 1), sd, rd, nd);
    model_cycle(pend_a, penalty(2, 1, 0), sa, ra, na);
    md = !rst && !ext_flush && id_valid && id_is_branch && !sd && (id_branch_taken != id_predict_taken);
    ma = !rst && !ext_flush && id_valid && id_is_branch && !sa && (id_branch_taken != id_predict_taken);
    fd = !rst && (md || ext_flush);
    fa = !rst && (ma || ext_flush);
    chk("stall", d_stall, sd);     chk("stall_rem", d_rem, rd);
    chk("mispredict", d_mis, md);  chk("flush", d_flush, fd);
    chk("a0_stall", a_stall, sa);  chk("a0_stall_rem", a_rem, ra);
    chk("a0_mispredict", a_mis, ma); chk("a0_flush", a_flush, fa);
    chk("c4_stall", c_stall, sd);  chk("c4_flush", c_flush, fd);
    s_stall = d_stall; s_rem = d_rem; s_mis = d_mis; s_flush = d_flush; s_stall_a = a_stall;
    @(posedge clk);
    pend_d = nd;
    pend_a = na;
    if (rst || perf_clr) begin
      ps16 = 0; pf16 = 0; ps4 = 0; pf4 = 0;
    end else begin
      if (sd) begin ps16 = (ps16 < 65535) ? ps16 + 1 : ps16; ps4 = (ps4 < 15) ? ps4 + 1 : ps4; end
      if (fd) begin pf16 = (pf16 < 65535) ? pf16 + 1 : pf16; pf4 = (pf4 < 15) ? pf4 + 1 : pf4; end
    end
    #1;
    chk("perf_stall_cycles", d_psc, ps16); chk("perf_flushes", d_pfl, pf16);
    chk("c4_perf_stall_cycles", c_psc, ps4); chk("c4_perf_flushes", c_pfl, pf4);
  endtask

  task automatic clr_in();
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_is_branch = 0; id_is_jalr = 0;
    id_branch_taken = 0; id_predict_taken = 0; ex_reg_write = 0; ex_mem_read = 0;
    ex_rd = '0; ext_flush = 0; perf_clr = 0;
  endtask

  task automatic ld_br5();
    clr_in();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5;
    id_valid = 1; id_is_branch = 1; id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01;
  endtask

  initial begin
    int f0;
    // Reset with hostile inputs: every handshake output must stay low.
    clr_in();
    id_valid = 1; id_is_branch = 1; id_branch_taken = 1; ext_flush = 1;
    ex_mem_read = 1; ex_rd = 5'd1; id_rs = {5'd0, 5'd1}; id_rs_used = 2'b01;
    step();
    chk("rst_stall", s_stall, 1'b0); chk("rst_flush", s_flush, 1'b0);
    chk("rst_mis", s_mis, 1'b0);     chk("rst_rem", s_rem, 3'd0);
    step();
    rst = 0;
    clr_in();
    step();

    // Load rd=5 -> branch rs1=5: two stall cycles, mispredict held off, then flush.
    ld_br5(); id_branch_taken = 1;
    step();
    chk("ldbr_c1_stall", s_stall, 1'b1); chk("ldbr_c1_rem", s_rem, 3'd1); chk("ldbr_c1_mis", s_mis, 1'b0);
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = '0;
    step();
    chk("ldbr_c2_stall", s_stall, 1'b1); chk("ldbr_c2_rem", s_rem, 3'd0); chk("ldbr_c2_mis", s_mis, 1'b0);
    f0 = pf16;
    step();
    chk("misp_stall", s_stall, 1'b0); chk("misp_mis", s_mis, 1'b1); chk("misp_flush", s_flush, 1'b1);
    chk("misp_perf_flushes", d_pfl, 16'(f0 + 1));

    // Load-use via port 1, then ex_rd=0 never matches.
    clr_in();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd7;
    id_valid = 1; id_rs = {5'd7, 5'd1}; id_rs_used = 2'b11;
    step();
    chk("ldu_stall", s_stall, 1'b1); chk("ldu_rem", s_rem, 3'd0);
    ex_mem_read = 0; ex_rd = '0;
    step();
    chk("ldu_after", s_stall, 1'b0);
    ex_mem_read = 1; ex_rd = 5'd0; id_rs = {5'd0, 5'd1};
    step();
    chk("ldu_x0", s_stall, 1'b0);

    // ALU rd=3 -> JALR rs1=3.
    clr_in();
    ex_reg_write = 1; ex_rd = 5'd3; id_valid = 1; id_is_jalr = 1;
    id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
    step();
    chk("alu_jalr_def", s_stall, 1'b1); chk("alu_jalr_a0", s_stall_a, 1'b0);

    // ext_flush in second cycle of load-branch stall.
    ld_br5();
    step();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = '0; ext_flush = 1;
    step();
    chk("xf_stall", s_stall, 1'b0); chk("xf_flush", s_flush, 1'b1); chk("xf_mis", s_mis, 1'b0);
    ext_flush = 0;
    step();
    chk("xf_idle", s_stall, 1'b0);

    // Saturation: 20 stall cycles on a 4-bit counter, then clear.
    clr_in(); perf_clr = 1;
    step();
    clr_in();
    ex_mem_read = 1; ex_rd = 5'd9; id_valid = 1; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    repeat (20) step();
    chk("sat_c4", c_psc, 4'd15); chk("sat_d16", d_psc, 16'd20);
    perf_clr = 1;
    step();
    chk("clr_c4", c_psc, 4'd0); chk("clr_d16", d_psc, 16'd0);

    // Async reset mid-HOLD.
    ld_br5();
    step();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = '0;
    #2;
    chk("hold_pre_rst", d_stall, 1'b1);
    rst = 1;
    #1;
    chk("async_rst_stall", d_stall, 1'b0); chk("async_rst_rem", d_rem, 3'd0);
    step();
    rst = 0;
    step();
    chk("post_rst_idle", s_stall, 1'b0);

    // Random traffic on a small register window to provoke matches.
    for (int i = 0; i < 600; i++) begin
      id_valid         = 1'($urandom_range(0, 3) != 0);
      id_rs            = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used       = 2'($urandom);
      id_is_branch     = 1'($urandom);
      id_is_jalr       = !id_is_branch && ($urandom_range(0, 3) == 0);
      id_branch_taken  = 1'($urandom);
      id_predict_taken = 1'($urandom);
      ex_reg_write     = 1'($urandom);
      ex_mem_read      = 1'($urandom);
      ex_rd            = 5'($urandom_range(0, 3));
      ext_flush        = ($urandom_range(0, 15) == 0);
      perf_clr         = ($urandom_range(0, 31) == 0);
      rst              = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_RS, default 2: number of ID-stage source register read ports checked.
REQ-002 SHALL have parameter REG_W, default 5: register address width.
REQ-003 SHALL have parameter LOAD_BR_PEN, default 2: stall cycles for a load in EX feeding a branch/JALR in ID; range 1..7.
REQ-004 SHALL have parameter LOAD_USE_PEN, default 1: stall cycles for a load in EX feeding a non-branch in ID; range 1..7.
REQ-005 SHALL have parameter ALU_BR_PEN, default 1: stall cycles for an ALU result in EX feeding a branch/JALR in ID; range 0..7.
REQ-006 SHALL have parameter CNT_W, default 16: performance counter width.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 id_valid  in  1  ID holds a real instruction.
REQ-010 id_rs  in  NUM_RS*REG_W  packed source addresses, port k at bits [k*REG_W +: REG_W].
REQ-011 id_rs_used  in  NUM_RS  per-port read enable.
REQ-012 id_is_branch  in  1  ID holds a conditional branch.
REQ-013 id_is_jalr  in  1  ID holds a JALR.
REQ-014 id_branch_taken / id_predict_taken  in  1 each  resolved and predicted direction.
REQ-015 ex_reg_write / ex_mem_read  in  1 each  EX instruction writes a register / is a load.
REQ-016 ex_rd  in  REG_W  EX destination.
REQ-017 ext_flush  in  1  flush request from a later stage (trap/exception).
REQ-018 perf_clr  in  1  synchronous clear of performance counters.
REQ-019 stall  out  1  hold PC and IF/ID, bubble into ID/EX.
REQ-020 flush  out  1  squash IF/ID.
REQ-021 mispredict  out  1  branch direction mispredicted in ID.
REQ-022 stall_remaining  out  3  stall cycles still pending after the current one.
REQ-023 perf_stall_cycles / perf_flushes  out  CNT_W each  saturating event counters.

Function
REQ-024 Dependency match for port k SHALL be: id_valid and id_rs_used[k] and ex_rd!=0 and id_rs[k]==ex_rd.
REQ-025 Required penalty P SHALL be chosen by priority: load+branch/JALR match -> LOAD_BR_PEN; load match -> LOAD_USE_PEN; ex_reg_write+branch/JALR match -> ALU_BR_PEN; else 0.
REQ-026 FSM states SHALL be IDLE and HOLD; counter cnt is 3 bits.
REQ-027 In IDLE with P>0, stall SHALL assert in the same cycle (combinational); if P>1, go to HOLD with cnt=P-1; else remain IDLE.
REQ-028 In HOLD, stall SHALL assert, detection SHALL be ignored, cnt decrements each cycle; at cnt==1 return to IDLE.
REQ-029 stall_remaining SHALL equal P-1 on the detect cycle, cnt-1 in HOLD, 0 otherwise.
REQ-030 mispredict SHALL assert only when id_valid, id_is_branch, stall=0 and id_branch_taken!=id_predict_taken.
REQ-031 flush SHALL equal mispredict or ext_flush.
REQ-032 ext_flush SHALL override everything: stall=0, FSM to IDLE, cnt=0 at next edge, mispredict=0.
REQ-033 perf_stall_cycles SHALL increment each cycle stall=1; perf_flushes SHALL increment each cycle flush=1; both saturate at all-ones.
REQ-034 perf_clr SHALL zero both counters at next edge, taking priority over increment.

Reset
REQ-035 While rst=1: FSM=IDLE, cnt=0, stall_remaining=0, perf counters=0; stall, flush, mispredict SHALL be 0 regardless of inputs.
REQ-036 Reset mid-HOLD SHALL abort the stall immediately (asynchronously).

Structure
REQ-037 A shared package SHALL hold the FSM state enum (HZ_IDLE, HZ_HOLD) and default penalty constants.
REQ-038 One sub-module, hz_sat_counter (parametrised width, inc, clr), SHALL implement both performance counters.

Verification
REQ-039 Load in EX rd=5, branch in ID rs1=5 -> stall=1 for exactly 2 cycles, stall_remaining 1 then 0, no mispredict in those cycles.
REQ-040 Load in EX rd=7, ADD in ID rs2=7 -> stall for 1 cycle; same with ex_rd=0 -> no stall.
REQ-041 ALU in EX rd=3, JALR in ID rs1=3, ALU_BR_PEN=0 build -> no stall; default build -> 1 cycle.
REQ-042 Branch predicted 0, resolved 1, no dependency -> flush=mispredict=1 that cycle, perf_flushes +1.
REQ-043 ext_flush in second cycle of a 2-cycle load-branch stall -> stall=0 that cycle, FSM IDLE next edge, flush=1.
REQ-044 CNT_W=4, 20 stall cycles -> perf_stall_cycles holds 15; perf_clr -> 0.
